// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lets two requesters share one combinational ALU.
// Each transaction takes one IDLE accept cycle, one EXEC cycle and a RESP hold phase.
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   reqN_valid/ready               request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_con       operands and ALU op code for requester N
//   rspN_valid/ready               response handshake for requester N
//   rsp_res, rsp_flags             shared result and {err, neg, carry, overflow, zero}
//   alu_a, alu_b, alu_con          operands and op code to the external ALU
//   alu_res, alu_neg, alu_carry,
//   alu_overflow, alu_zero         result and flags from the external ALU
//   busy                           high whenever the FSM is not idle
//   op_count                       count of completed transactions, wraps at 16 bits
module alu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_con,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_con,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_res,
  output logic [4:0]      rsp_flags,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_con,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_neg,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  output logic            busy,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q, res_q;
  logic [3:0]        con_q;
  logic [4:0]        flags_q;
  logic              owner_q;
  logic              last_q;
  logic [15:0]       count_q;

  logic              grant;
  logic              accept;
  logic              in_idle, in_exec, in_resp;
  logic              rsp_done;
  logic              illegal, arith;
  logic [XLEN-1:0]   res_d;
  logic [4:0]        flags_d;

  // Outputs are gated by rst so that they read zero combinationally while reset is held.
  assign in_idle = (state_q == StIdle) && !rst;
  assign in_exec = (state_q == StExec) && !rst;
  assign in_resp = (state_q == StResp) && !rst;

  // Tie goes to the requester not served last; otherwise the sole valid requester wins.
  assign grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  assign req0_ready = in_idle && req0_valid && !grant;
  assign req1_ready = in_idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = in_resp && !owner_q;
  assign rsp1_valid = in_resp && owner_q;
  // Non-owner rsp_ready is ignored because its rsp_valid is low.
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign rsp_res   = in_resp ? res_q : '0;
  assign rsp_flags = in_resp ? flags_q : 5'b0;

  assign alu_a   = in_exec ? a_q : '0;
  assign alu_b   = in_exec ? b_q : '0;
  assign alu_con = in_exec ? con_q : 4'b0;

  assign busy     = (state_q != StIdle) && !rst;
  assign op_count = count_q;

  // Result shaping: codes above 1100 report an error and ignore the ALU; carry and
  // overflow are meaningful only for add/sub.
  assign illegal = con_q > 4'd12;
  assign arith   = (con_q == 4'd0) || (con_q == 4'd1);

  always_comb begin
    res_d   = '0;
    flags_d = 5'b10000;
    if (!illegal) begin
      res_d   = alu_res;
      flags_d = {1'b0, alu_neg, arith && alu_carry, arith && alu_overflow, alu_zero};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      con_q   <= 4'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      flags_q <= 5'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= grant ? req1_a : req0_a;
        b_q     <= grant ? req1_b : req0_b;
        con_q   <= grant ? req1_con : req0_con;
        owner_q <= grant;
      end
      if (state_q == StExec) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
      if (rsp_done) begin
        last_q  <= owner_q;
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset-in-RESP and counter-wrap sequences,
// then randomized transactions checked against a behavioural model. The shared ALU is
// modelled here as well.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_con, req1_con;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_res;
  logic [4:0]  rsp_flags;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_con;
  logic        alu_neg, alu_carry, alu_overflow, alu_zero, alu_carry_raw;
  logic        busy;
  logic [15:0] op_count;
  logic        force_carry;

  int total = 0;
  int bad   = 0;
  int last_m;
  int cnt_m;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_con(req0_con),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_con(req1_con),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_con(alu_con),
    .alu_res(alu_res), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // Plain-arithmetic ALU: returns {carry, overflow, result}. Non add/sub ops still report
  // the add carry/overflow so that masking in the arbiter is exercised.
  function automatic logic [33:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] con);
    logic [32:0] sadd, ssub;
    logic [31:0] res;
    logic        c, v;
    sadd = {1'b0, a} + {1'b0, b};
    ssub = {1'b0, a} + {1'b0, ~b} + 33'd1;
    c = sadd[32];
    v = (a[31] == b[31]) && (sadd[31] != a[31]);
    case (con)
      4'd0:  res = sadd[31:0];
      4'd1:  begin
        res = ssub[31:0];
        c   = ssub[32];
        v   = (a[31] != b[31]) && (ssub[31] != a[31]);
      end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  res = (a < b) ? 32'd1 : 32'd0;
      4'd7:  res = a;
      4'd8:  res = sadd[31:0];
      4'd9:  res = b;
      4'd10: res = a << b[4:0];
      4'd11: res = $signed(a) >>> b[4:0];
      4'd12: res = a >> b[4:0];
      default: res = a ^ b ^ 32'hDEADBEEF;
    endcase
    return {c, v, res};
  endfunction

  // Expected response {flags, result} from the arbiter's rules.
  function automatic logic [36:0] expect_rsp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] con);
    logic [33:0] r;
    logic        ar;
    if (con > 4'd12) return {5'b10000, 32'd0};
    r  = alu_calc(a, b, con);
    ar = (con < 4'd2);
    return {1'b0, r[31], ar & r[33], ar & r[32], (r[31:0] == 32'd0), r[31:0]};
  endfunction

  always_comb begin
    {alu_carry_raw, alu_overflow, alu_res} = alu_calc(alu_a, alu_b, alu_con);
    alu_carry = alu_carry_raw | force_carry;
    alu_neg   = alu_res[31];
    alu_zero  = (alu_res == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    force_carry = 1'b0;
  endtask

  // One full transaction from IDLE through the response handshake.
  task automatic txn(input logic v0, input logic v1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                     input int stall, input logic fc, input logic own,
                     input logic [31:0] eres, input logic [4:0] eflg);
    logic [1:0] ev;
    ev = own ? 2'b01 : 2'b10;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_con = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_con = c1;
    force_carry = fc;
    #1;
    chk("grant", {req0_ready, req1_ready}, {!own, own});
    chk("idle_busy", busy, 0);
    chk("idle_alu", {alu_a, alu_b}, 0);
    @(negedge clk);
    if (own) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, own ? a1 : a0);
    chk("exec_alu_b", alu_b, own ? b1 : b0);
    chk("exec_alu_con", alu_con, own ? c1 : c0);
    chk("exec_rspv", {rsp0_valid, rsp1_valid}, 0);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    #1;
    chk("resp_valid", {rsp0_valid, rsp1_valid}, ev);
    chk("resp_res", rsp_res, eres);
    chk("resp_flags", rsp_flags, eflg);
    chk("resp_alu", {alu_a, alu_b, alu_con}, 0);
    for (int i = 0; i < stall; i++) begin
      if (own) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("hold_valid", {rsp0_valid, rsp1_valid}, ev);
      chk("hold_res", {rsp_flags, rsp_res}, {eflg, eres});
      chk("hold_ready", {req0_ready, req1_ready, busy}, 3'b001);
    end
    rsp0_ready = !own; rsp1_ready = own;
    @(negedge clk);
    idle_inputs();
    #1;
    cnt_m  = (cnt_m + 1) & 16'hFFFF;
    last_m = own;
    chk("op_count", op_count, cnt_m);
    chk("done_valid", {rsp0_valid, rsp1_valid, busy}, 0);
  endtask

  typedef struct {
    logic v0, v1;
    logic [31:0] a0, b0;
    logic [3:0] c0;
    logic [31:0] a1, b1;
    logic [3:0] c1;
    int stall;
    logic fc, own;
    logic [31:0] res;
    logic [4:0] flg;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic v0, v1, own;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0] c0, c1;
    logic [36:0] e;

    // Sequence assumes it starts straight out of reset (req0 wins the first tie).
    tbl[0] = '{1, 1, 32'h7FFFFFFF, 32'h1, 4'h0, 32'h5, 32'h5, 4'h1, 0, 0, 0,
               32'h80000000, 5'b01010};
    tbl[1] = '{1, 1, 32'h7FFFFFFF, 32'h1, 4'h0, 32'h5, 32'h5, 4'h1, 0, 0, 1,
               32'h0, 5'b00101};
    tbl[2] = '{1, 1, 32'hFFFFFFFF, 32'h0, 4'h4, 32'h1, 32'h2, 4'h0, 0, 1, 0,
               32'hFFFFFFFF, 5'b01000};
    tbl[3] = '{0, 1, 32'h0, 32'h0, 4'h0, 32'h12345678, 32'h9, 4'hE, 0, 0, 1,
               32'h0, 5'b10000};
    tbl[4] = '{1, 0, 32'hF0F0F0F0, 32'hFF00FF00, 4'h2, 32'h0, 32'h0, 4'h0, 5, 0, 0,
               32'hF000F000, 5'b01000};
    tbl[5] = '{1, 1, 32'h1, 32'h2, 4'h6, 32'hFFFFFFFF, 32'h1, 4'h5, 0, 0, 1,
               32'h1, 5'b00000};
    tbl[6] = '{1, 1, 32'h1, 32'd31, 4'hA, 32'h0, 32'h0, 4'h0, 0, 0, 0,
               32'h80000000, 5'b01000};
    tbl[7] = '{1, 0, 32'h0, 32'h1, 4'h1, 32'h0, 32'h0, 4'h0, 1, 0, 0,
               32'hFFFFFFFF, 5'b01000};
    tbl[8] = '{0, 1, 32'h0, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h1, 4'h0, 0, 0, 1,
               32'h0, 5'b00101};

    req0_a = '0; req0_b = '0; req0_con = '0;
    req1_a = '0; req1_b = '0; req1_con = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 0);
    chk("rst_res_flags", {rsp_flags, rsp_res}, 0);
    chk("rst_count", op_count, 0);
    rst = 1'b0;
    last_m = 1;
    cnt_m  = 0;

    for (int i = 0; i < 9; i++)
      txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].a1, tbl[i].b1,
          tbl[i].c1, tbl[i].stall, tbl[i].fc, tbl[i].own, tbl[i].res, tbl[i].flg);

    // Reset while a response is pending: it must be dropped and arbitration restarted.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_con = 4'h0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_resp", rsp1_valid, 1);
    req0_valid = 1'b1; req1_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rst_resp_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 0);
    chk("rst_resp_res", {rsp_flags, rsp_res, alu_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_count", op_count, 0);
    chk("post_rst_tie", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b1000);
    idle_inputs();
    last_m = 1;
    cnt_m  = 0;

    // Randomized transactions against the model.
    for (int n = 0; n < 150; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = $urandom; b0 = (n % 4 == 0) ? a0 : $urandom; c0 = 4'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom_range(0, 40); c1 = 4'($urandom_range(0, 15));
      own = (v0 && v1) ? (last_m == 0) : v1;
      e = own ? expect_rsp(a1, b1, c1) : expect_rsp(a0, b0, c0);
      txn(v0, v1, a0, b0, c0, a1, b1, c1, $urandom_range(0, 3), 1'b0, own,
          e[31:0], e[36:32]);
    end

    // Counter wrap: preload near the top, then complete three transactions.
    @(negedge clk);
    force dut.count_q = 16'hFFFD;
    @(negedge clk);
    release dut.count_q;
    cnt_m = 16'hFFFD;
    #1;
    chk("preload_count", op_count, cnt_m);
    for (int n = 0; n < 3; n++)
      txn(1'b1, 1'b0, 32'd7, 32'd9, 4'h2, 32'd0, 32'd0, 4'h0, 0, 1'b0, 1'b0,
          32'd1, 5'b00000);
    chk("wrap_zero", op_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
